// File: rtl/instr_mem_loader_if.sv
// Byte stream and instruction memory write port of the program loader.
// The loader uses the master side; the byte source and memory use the slave side.
interface instr_mem_loader_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_write_enable;
  logic [31:0] mem_write_addr;
  logic [31:0] mem_write_data;

  modport master (
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output mem_write_enable,
    output mem_write_addr,
    output mem_write_data
  );

  modport slave (
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  mem_write_enable,
    input  mem_write_addr,
    input  mem_write_data
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Byte-stream program loader: LEN_LO, LEN_HI, then N little-endian words.
// Optional LOADER_CHECKSUM_EN appends an XOR checksum byte after the payload.
module instr_mem_loader #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter logic [31:0] ADDR_STEP = 32'h1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  instr_mem_loader_if.master bus,
  output logic               core_reset,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [15:0]        words_written
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
`ifdef LOADER_CHECKSUM_EN
    , S_CHECK
`endif
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_FINAL = S_CHECK;
`else
  localparam state_t S_FINAL = S_DONE;
`endif

  localparam logic [15:0] DEPTH = 16'(MEM_DEPTH);

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        ready_q, ready_d;
  logic        crst_q, crst_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        xfer;
  logic [15:0] n_full;
  logic [15:0] cnt_inc;

  assign xfer    = bus.byte_valid && ready_q;
  assign n_full  = {bus.byte_in, len_q[7:0]};
  assign cnt_inc = cnt_q + 16'd1;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    word_d  = word_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LEN_LO;
          cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = bus.byte_in;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = bus.byte_in;
          idx_d       = '0;
          if (n_full == 16'd0)
            state_d = S_FINAL;
          else if (n_full > DEPTH)
            state_d = S_ERROR;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          word_d[{idx_q, 3'b000} +: 8] = bus.byte_in;
          idx_d = idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ bus.byte_in;
`endif
          if (idx_q == 2'd3) begin
            state_d = S_WRITE;
            wdata_d = word_d;
            // 32-bit product and sum wrap silently
            addr_d  = BASE_ADDR
                    + ({16'd0, cnt_q} * ADDR_STEP);
          end
        end
      end
      S_WRITE: begin
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == len_q) ? S_FINAL : S_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (xfer)
          state_d = (bus.byte_in == csum_q) ? S_DONE
                                            : S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, decoded from the next state
    ready_d = (state_d == S_LEN_LO)
           || (state_d == S_LEN_HI)
           || (state_d == S_DATA);
`ifdef LOADER_CHECKSUM_EN
    ready_d = ready_d || (state_d == S_CHECK);
`endif
    we_d   = (state_d == S_WRITE);
    busy_d = ready_d || we_d;
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERROR);
    crst_d = (state_d != S_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      crst_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      crst_q  <= crst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign bus.byte_ready       = ready_q;
  assign bus.mem_write_enable = we_q;
  assign bus.mem_write_addr   = addr_q;
  assign bus.mem_write_data   = wdata_q;
  assign core_reset           = crst_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign error                = err_q;
  assign words_written        = cnt_q;

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Byte-stream program loader and the write-side counterpart of the instruction memory: assembles little-endian 32-bit words from an 8-bit valid/ready stream and writes them sequentially into instruction memory.
- Holds the processor core in reset while loading and releases it when the image is complete.
- Sits between an external byte source (host or debug link) and the instruction memory write port, next to the processor top.

Parameters:
- MEM_DEPTH, 256, maximum number of 32-bit words accepted; must be ≤ 65535.
- BASE_ADDR, 0, instruction address of the first word written.
- ADDR_STEP, 1, address increment per word, matching the PC increment.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a load; honoured only in IDLE, DONE or ERROR.
- byte_in  input  8  stream data.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader can accept a byte; transfer occurs when byte_valid && byte_ready.
- mem_write_enable  output  1  one-cycle write strobe to instruction memory.
- mem_write_addr  output  32  write address.
- mem_write_data  output  32  write data.
- core_reset  output  1  holds the core in reset; high except in DONE.
- busy  output  1  load in progress.
- done  output  1  image loaded; level signal.
- error  output  1  load aborted; level signal.
- words_written  output  16  number of words written in the current load.

Behaviour:
- Reset values: state IDLE; byte_ready = 0, mem_write_enable = 0, mem_write_addr = BASE_ADDR, mem_write_data = 0, core_reset = 1, busy = 0, done = 0, error = 0, words_written = 0.
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N×4 payload bytes. Byte 0 of each word maps to [7:0], byte 3 to [31:24].
- States and transitions:
  - IDLE: on start → LEN_LO; words_written cleared; core_reset stays 1.
  - LEN_LO: byte_ready = 1; on transfer latch N[7:0] → LEN_HI.
  - LEN_HI: byte_ready = 1; on transfer latch N[15:8], then:
    - N == 0 → DONE.
    - N > MEM_DEPTH → ERROR.
    - otherwise → DATA with byte index 0.
  - DATA: byte_ready = 1; each transfer shifts the byte into the word register and increments the byte index mod 4. The transfer that completes the 4th byte moves to WRITE on the next edge.
  - WRITE: byte_ready = 0 for exactly one cycle.
    - mem_write_enable = 1, mem_write_addr = BASE_ADDR + words_written×ADDR_STEP, mem_write_data = assembled word.
    - Next edge: words_written increments; → DONE if it now equals N, else → DATA.
  - DONE: done = 1, busy = 0, core_reset = 0. start → LEN_LO, with core_reset = 1 and done = 0 from the next cycle.
  - ERROR: error = 1, busy = 0, core_reset = 1. start → LEN_LO and clears error.
- busy = 1 in LEN_LO, LEN_HI, DATA and WRITE.
- Latency: the word becomes visible on the memory port in the cycle after its 4th byte is accepted. Sustained throughput is 4 bytes per 5 cycles.
- Boundaries:
  - byte_valid while byte_ready = 0 is ignored; the source holds its data.
  - start while busy is ignored.
  - Bytes arriving in IDLE, DONE or ERROR are not accepted.
  - N == MEM_DEPTH is legal.
  - Asynchronous reset mid-load returns to the reset values immediately. Words already written stay in memory; the core stays held.
  - Address arithmetic is 32-bit and wraps silently.
  - mem_write_addr and mem_write_data hold their last values outside WRITE.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - A state CHECK follows the last WRITE (instead of DONE) with byte_ready = 1.
  - The received byte is compared to the XOR of all payload bytes. Match → DONE; mismatch → ERROR.
  - For N == 0 the expected checksum is 8'h00, and CHECK follows LEN_HI.
- Undefined: no CHECK state and no checksum byte in the stream; the behaviour is exactly as above.

Test Plan:
- Reset then start with stream 02 00 | 78 56 34 12 | EF BE AD DE, valid held high → writes 0x12345678 @0 and 0xDEADBEEF @1, one cycle each. Then done = 1, core_reset = 0, words_written = 2.
- Same stream with byte_valid toggling 1/0 every cycle → identical writes and final state. No byte is accepted while byte_ready = 0.
- Stream 00 00 → DONE directly after LEN_HI, no mem_write_enable pulse, words_written = 0.
- MEM_DEPTH = 4, stream 05 00 → ERROR, error = 1, core_reset = 1, no writes. A following start plus 01 00 AA BB CC DD → writes 0xDDCCBBAA @0, then done.
- Reset asserted after 6 payload bytes of a 2-word load → outputs return to reset values asynchronously, with exactly one write (word 0) observed.
- LOADER_CHECKSUM_EN, stream 01 00 01 02 04 08 0F → DONE. Trailing byte 0E → ERROR, with the word still written.
